// File: rtl/blitter_pkg.sv
// Shared widths, arbiter state type and index helper for the blitter write path.
package blitter_pkg;

    localparam int BLIT_ADDR_W = 26;
    localparam int BLIT_BE_W   = 4;
    localparam int BLIT_DATA_W = 32;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // (a + b) mod n for operands already inside 0..n-1.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/blitter_rr_pick.sv
// Combinational rotating-priority picker: first valid index at or after start, wrapping.
module blitter_rr_pick
    import blitter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    logic [NUM_REQ-1:0] rot_valid;
    logic [ID_W-1:0]    offset;

    // rot_valid[0] is the requester at start, so a plain lowest-index search is the round-robin order.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot_valid[gi] = valid[ID_W'(wrap_add(int'(start), gi, NUM_REQ))];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                offset = ID_W'(k);
            end
        end
    end

    assign winner = ID_W'(wrap_add(int'(start), int'(offset), NUM_REQ));
    assign any    = |valid;

endmodule

// File: rtl/blitter_wr_arbiter.sv
// Burst arbiter sharing the blitter write FIFO between drawing engines, with a registered output slice.
// Define BLIT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module blitter_wr_arbiter
    import blitter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 16,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*BLIT_ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*BLIT_BE_W-1:0]   req_byte_en,
    input  logic [NUM_REQ*BLIT_DATA_W-1:0] req_data,
    output logic [BLIT_ADDR_W-1:0]         out_address,
    output logic [BLIT_BE_W-1:0]           out_byte_en,
    output logic [BLIT_DATA_W-1:0]         out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ID_W-1:0]                grant_id,
    output logic                           grant_active
);

    arb_state_t             state_reg;
    arb_state_t             state_next;
    logic [ID_W-1:0]        grant_id_reg;
    logic [7:0]             beat_cnt_reg;
    logic                   out_valid_reg;
    logic [BLIT_ADDR_W-1:0] out_address_reg;
    logic [BLIT_BE_W-1:0]   out_byte_en_reg;
    logic [BLIT_DATA_W-1:0] out_data_reg;

    logic [BLIT_ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [BLIT_BE_W-1:0]   be_arr   [NUM_REQ];
    logic [BLIT_DATA_W-1:0] data_arr [NUM_REQ];

    logic [ID_W-1:0] pick_start;
    logic [ID_W-1:0] pick_winner;
    logic            pick_any;
    logic            in_grant;
    logic            slice_free;
    logic            grant_valid;
    logic            accept;
    logic            last_beat;
    logic            burst_done;

    assign in_grant    = (state_reg == ARB_GRANT);
    assign slice_free  = !out_valid_reg || out_ready;
    assign grant_valid = req_valid[grant_id_reg];
    assign accept      = in_grant && slice_free && grant_valid;
    assign last_beat   = ({1'b0, beat_cnt_reg} + 9'd1) == 9'(BURST_LEN);
    // A stalled slice never ends the burst; only a full burst or an idle grantee does.
    assign burst_done  = in_grant && ((accept && last_beat) || (slice_free && !grant_valid));

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]  = req_address[gi*BLIT_ADDR_W +: BLIT_ADDR_W];
            assign be_arr[gi]    = req_byte_en[gi*BLIT_BE_W +: BLIT_BE_W];
            assign data_arr[gi]  = req_data[gi*BLIT_DATA_W +: BLIT_DATA_W];
            assign req_ready[gi] = in_grant && slice_free && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

`ifdef BLIT_ARB_FIXED_PRIO_EN
    assign pick_start = '0;
`else
    logic [ID_W-1:0] rr_ptr_reg;

    assign pick_start = rr_ptr_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_reg <= '0;
        end else if (!in_grant && pick_any) begin
            rr_ptr_reg <= ID_W'(wrap_add(int'(pick_winner), 1, NUM_REQ));
        end
    end
`endif

    blitter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .valid   (req_valid),
        .start   (pick_start),
        .winner  (pick_winner),
        .any     (pick_any)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE:  if (pick_any)   state_next = ARB_GRANT;
            ARB_GRANT: if (burst_done) state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ARB_IDLE;
            grant_id_reg <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (!in_grant && pick_any) begin
                grant_id_reg <= pick_winner;
                beat_cnt_reg <= '0;
            end else if (accept) begin
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
        end
    end

    // Output slice keeps draining in IDLE so a held beat survives the end of its burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg   <= 1'b0;
            out_address_reg <= '0;
            out_byte_en_reg <= '0;
            out_data_reg    <= '0;
        end else if (accept) begin
            out_valid_reg   <= 1'b1;
            out_address_reg <= addr_arr[grant_id_reg];
            out_byte_en_reg <= be_arr[grant_id_reg];
            out_data_reg    <= data_arr[grant_id_reg];
        end else if (slice_free) begin
            out_valid_reg   <= 1'b0;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_address  = out_address_reg;
    assign out_byte_en  = out_byte_en_reg;
    assign out_data     = out_data_reg;
    assign grant_id     = grant_id_reg;
    assign grant_active = in_grant;

endmodule

// File: tb/tb_blitter_wr_arbiter.sv
// Self-checking bench for blitter_wr_arbiter: random-data engines, a spec-level model and an in-order beat scoreboard.
module tb_blitter_wr_arbiter;
    import blitter_pkg::*;

    localparam int N   = 4;
    localparam int BL  = 16;
    localparam int IDW = 2;
`ifdef BLIT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef logic [61:0] beat_t;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*26-1:0] req_address;
    logic [N*4-1:0] req_byte_en;
    logic [N*32-1:0] req_data;
    logic [25:0]    out_address;
    logic [3:0]     out_byte_en;
    logic [31:0]    out_data;
    logic           out_valid;
    logic           out_ready;
    logic [IDW-1:0] grant_id;
    logic           grant_active;

    always #5 clock = ~clock;

    blitter_wr_arbiter #(.NUM_REQ(N), .BURST_LEN(BL)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_address  (req_address),
        .req_byte_en  (req_byte_en),
        .req_data     (req_data),
        .out_address  (out_address),
        .out_byte_en  (out_byte_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    // Engine sources
    bit          s_v    [N];
    logic [25:0] s_addr [N];
    logic [3:0]  s_be   [N];
    logic [31:0] s_data [N];
    int          rem    [N];
    int          gap    [N];
    int          ready_pct;
    int          stall;
    bit          force_idle;
    bit          chk_en;

    // Reference model
    bit    m_active;
    int    m_gid;
    int    m_cnt;
    int    m_rr;
    bit    m_hold;
    beat_t m_hbeat;
    beat_t acc_q [$];
    int    g_ids [$];
    int    g_beats [$];

    int errors = 0;
    int checks = 0;

    always_comb begin
        req_valid   = '0;
        req_address = '0;
        req_byte_en = '0;
        req_data    = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = s_v[i];
            req_address[i*26 +: 26] = s_addr[i];
            req_byte_en[i*4 +: 4]   = s_be[i];
            req_data[i*32 +: 32]    = s_data[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic beat_t src_beat(input int i);
        return {s_addr[i], s_be[i], s_data[i]};
    endfunction

    task automatic clear_logs();
        g_ids.delete();
        g_beats.delete();
    endtask

    task automatic cycle();
        logic [N-1:0] hs;
        logic [N-1:0] vpre;
        bit free;
        bit acc;
        bit ohs;
        bit gv;
        bit rst_now;
        int w;
        for (int i = 0; i < N; i++) begin
            if (force_idle) begin
                s_v[i] = 1'b0;
            end else if (!s_v[i] && rem[i] > 0 && $urandom_range(99) >= gap[i]) begin
                s_v[i]    = 1'b1;
                s_addr[i] = 26'($urandom);
                s_be[i]   = 4'($urandom);
                s_data[i] = $urandom;
                rem[i]--;
            end
        end
        if (force_idle) out_ready = 1'b0;
        else if (stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else out_ready = ($urandom_range(99) < ready_pct);
        #2;
        free = !m_hold || out_ready;
        if (chk_en) begin
            chk("grant_active", grant_active, m_active);
            if (m_active) chk("grant_id", grant_id, m_gid);
            chk("out_valid", out_valid, m_hold);
            if (m_hold) chk("out_hold", {out_address, out_byte_en, out_data}, m_hbeat);
            chk("req_ready", req_ready, (m_active && free) ? (64'd1 << m_gid) : 64'd0);
        end
        rst_now = reset;
        vpre = req_valid;
        gv   = m_active ? s_v[m_gid] : 1'b0;
        acc  = m_active && free && gv;
        hs   = req_valid & req_ready & {N{!reset}};
        ohs  = out_valid && out_ready && !reset;
        if (ohs) begin
            if (acc_q.size() == 0) chk("out_extra", 1, 0);
            else chk("out_beat", {out_address, out_byte_en, out_data}, acc_q.pop_front());
        end
        for (int i = 0; i < N; i++) if (hs[i]) acc_q.push_back(src_beat(i));
        if (acc && !rst_now) m_hbeat = src_beat(m_gid);
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) s_v[i] = 1'b0;
        if (rst_now) begin
            m_active = 1'b0;
            m_gid    = 0;
            m_cnt    = 0;
            m_rr     = 0;
            m_hold   = 1'b0;
            acc_q.delete();
        end else begin
            if (acc) m_hold = 1'b1;
            else if (free) m_hold = 1'b0;
            if (m_active) begin
                if (acc) m_cnt++;
                if ((acc && m_cnt == BL) || (free && !gv)) begin
                    m_active = 1'b0;
                    g_beats.push_back(m_cnt);
                end
            end else begin
                w = pick(vpre, FIXED ? 0 : m_rr);
                if (w >= 0) begin
                    m_active = 1'b1;
                    m_gid    = w;
                    m_cnt    = 0;
                    g_ids.push_back(w);
                    if (!FIXED) m_rr = (w + 1) % N;
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset      = 1'b1;
        force_idle = 1'b1;
        repeat (n) cycle();
        reset      = 1'b0;
        force_idle = 1'b0;
    endtask

    function automatic bit all_quiet();
        for (int i = 0; i < N; i++) if (rem[i] > 0 || s_v[i]) return 1'b0;
        return !m_active && !m_hold;
    endfunction

    task automatic drain(input string tag, input int maxc);
        int k = 0;
        while (!all_quiet() && k < maxc) begin
            cycle();
            k++;
        end
        chk(tag, k < maxc, 1);
    endtask

    task automatic run_grants(input string tag, input int n, input int maxc);
        int k = 0;
        while (g_ids.size() < n && k < maxc) begin
            cycle();
            k++;
        end
        chk(tag, k < maxc, 1);
    endtask

    initial begin
        int fixed_exp [4];
        int rr_exp [4];
        for (int i = 0; i < N; i++) begin
            s_v[i] = 1'b0; s_addr[i] = '0; s_be[i] = '0; s_data[i] = '0;
            rem[i] = 0; gap[i] = 0;
        end
        ready_pct = 100; stall = 0; force_idle = 1'b0; chk_en = 1'b0;
        out_ready = 1'b0; reset = 1'b1;
        m_active = 1'b0; m_gid = 0; m_cnt = 0; m_rr = 0; m_hold = 1'b0; m_hbeat = '0;

        do_reset(3);
        chk_en = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_grant_active", grant_active, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_data", {out_address, out_byte_en, out_data}, 0);

        // Single engine, 40 beats: bursts of 16, 16, 8
        clear_logs();
        rem[0] = 40;
        drain("t1_timeout", 200);
        chk("t1_grants", g_beats.size(), 3);
        if (g_beats.size() == 3) begin
            chk("t1_b0", g_beats[0], 16);
            chk("t1_b1", g_beats[1], 16);
            chk("t1_b2", g_beats[2], 8);
            for (int k = 0; k < 3; k++) chk("t1_id", g_ids[k], 0);
        end

        // All engines continuously valid: 0,1,2,3,0 with full bursts
        do_reset(1);
        clear_logs();
        for (int i = 0; i < N; i++) rem[i] = 64;
        run_grants("t2_timeout", 6, 400);
        for (int i = 0; i < N; i++) rem[i] = 0;
        drain("t2_drain", 200);
        if (g_beats.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t2_id", g_ids[k], k % N);
                chk("t2_beats", g_beats[k], 16);
            end
        end else chk("t2_count", g_beats.size(), 5);

        // Backpressure mid-burst never releases the grant
        clear_logs();
        rem[1] = 20;
        repeat (6) cycle();
        stall = 5;
        drain("t3_timeout", 200);
        chk("t3_grants", g_beats.size(), 2);
        if (g_beats.size() == 2) begin
            chk("t3_b0", g_beats[0], 16);
            chk("t3_b1", g_beats[1], 4);
        end

        // Grantee goes idle after 3 beats, waiting engine granted next
        clear_logs();
        rem[2] = 3;
        rem[1] = 5;
        drain("t4_timeout", 200);
        chk("t4_grants", g_ids.size(), 2);
        if (g_ids.size() == 2) begin
            chk("t4_id0", g_ids[0], 2);
            chk("t4_b0", g_beats[0], 3);
            chk("t4_id1", g_ids[1], 1);
            chk("t4_b1", g_beats[1], 5);
        end

        // Reset mid-burst with a beat held in the slice
        clear_logs();
        rem[3] = 10;
        stall = 0;
        begin
            int k = 0;
            while (!(m_active && m_hold && m_cnt >= 4) && k < 60) begin
                cycle();
                k++;
            end
            chk("t5_setup", k < 60, 1);
        end
        do_reset(1);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_grant_active", grant_active, 0);
        clear_logs();
        rem[1] = 2;
        drain("t5_timeout", 200);
        if (g_ids.size() >= 2) begin
            chk("t5_rr_first", g_ids[0], 1);
            chk("t5_rr_second", g_ids[1], 3);
        end else chk("t5_count", g_ids.size(), 2);

        // Engines 0 and 3 always valid: priority vs round-robin order
        do_reset(1);
        clear_logs();
        rem[0] = 40;
        rem[3] = 40;
        fixed_exp = '{0, 0, 0, 3};
        rr_exp    = '{0, 3, 0, 3};
        run_grants("t6_timeout", 4, 400);
        if (g_ids.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("t6_id", g_ids[k], FIXED ? fixed_exp[k] : rr_exp[k]);
        end
        rem[0] = 0;
        rem[3] = 0;
        drain("t6_drain", 200);

        // Random traffic with random FIFO backpressure
        clear_logs();
        for (int i = 0; i < N; i++) begin
            rem[i] = $urandom_range(30, 5);
            gap[i] = 30;
        end
        ready_pct = 70;
        drain("t7_timeout", 3000);
        chk("scoreboard_empty", acc_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
